// File: rtl/pe_mac_fx.sv
// Fixed-point processing element: holds one matrix row in a local RAM and
// accumulates a saturating Q-format dot product against a broadcast vector.
module pe_mac_fx #(
    parameter int L_RAM_SIZE = 4,
    parameter int MUL_LAT    = 3,
    parameter int FRAC_BITS  = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic signed [31:0]           ain,
    input  logic        [31:0]           din,
    input  logic        [L_RAM_SIZE-1:0] addr,
    input  logic                         we,
    input  logic                         valid,
    output logic                         dvalid,
    output logic signed [31:0]           dout,
    output logic                         ovf
);

    localparam int DEPTH = 1 << L_RAM_SIZE;
    localparam logic signed [63:0] SMAX64 = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SMIN64 = -64'sh0000_0000_8000_0000;

    // Scales the full product back to Q-format and clips it to 32 bits.
    // Returns {saturated, value}.
    function automatic logic [32:0] sat_term(input logic signed [63:0] p);
        logic signed [63:0] t;
        t = p >>> FRAC_BITS;
        if (t > SMAX64) return {1'b1, 32'h7FFF_FFFF};
        if (t < SMIN64) return {1'b1, 32'h8000_0000};
        return {1'b0, t[31:0]};
    endfunction

    // 33-bit add clipped to the 32-bit signed range. Returns {saturated, value}.
    function automatic logic [32:0] sat_add(input logic signed [31:0] a,
                                            input logic signed [31:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) return {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        return {1'b0, s[31:0]};
    endfunction

    logic [31:0] lram [DEPTH];

    always_ff @(posedge aclk) begin
        if (we) lram[addr] <= din;
    end

    // Stage p0: capture the broadcast element and the row element together.
    // The asynchronous read sees the pre-write content when we and valid coincide.
    logic signed [31:0] a_p0;
    logic signed [31:0] w_p0;
    logic               vld_p0;

    always_ff @(posedge aclk) begin
        if (valid) begin
            a_p0 <= ain;
            w_p0 <= lram[addr];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) vld_p0 <= 1'b0;
        else          vld_p0 <= valid;
    end

    // Stage p1..: product, registered MUL_LAT-1 times for retiming into the multiplier.
    logic signed [63:0] prod_p1;
    logic signed [63:0] prod_acc;
    logic               vld_acc;

    assign prod_p1 = a_p0 * w_p0;

    if (MUL_LAT == 1) begin : g_mul_direct
        assign prod_acc = prod_p1;
        assign vld_acc  = vld_p0;
    end else begin : g_mul_pipe
        logic signed [63:0] prod_pn [MUL_LAT-1];
        logic [MUL_LAT-2:0] vld_pn;

        always_ff @(posedge aclk) begin
            prod_pn[0] <= prod_p1;
            for (int i = 1; i < MUL_LAT-1; i++) prod_pn[i] <= prod_pn[i-1];
        end

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                vld_pn <= '0;
            end else begin
                vld_pn[0] <= vld_p0;
                for (int i = 1; i < MUL_LAT-1; i++) vld_pn[i] <= vld_pn[i-1];
            end
        end

        assign prod_acc = prod_pn[MUL_LAT-2];
        assign vld_acc  = vld_pn[MUL_LAT-2];
    end

    // Final stage: saturating accumulate; ovf is sticky until reset.
    logic signed [31:0] term;
    logic signed [31:0] sum;
    logic               term_sat;
    logic               sum_sat;

    assign {term_sat, term} = sat_term(prod_acc);
    assign {sum_sat, sum}   = sat_add(dout, term);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            dvalid <= 1'b0;
            dout   <= '0;
            ovf    <= 1'b0;
        end else begin
            dvalid <= vld_acc;
            if (vld_acc) begin
                dout <= sum;
                if (term_sat || sum_sat) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_fx.sv
// Self-checking bench for pe_mac_fx: directed scenarios plus randomized traffic
// against a queue-based arithmetic reference model.
module tb_pe_mac_fx;

    localparam int MUL_LAT   = 3;
    localparam int FRAC_BITS = 16;
    localparam int LAT       = MUL_LAT + 1;
    localparam longint SMAX  = 64'sh7FFF_FFFF;
    localparam longint SMIN  = -SMAX - 1;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn, we, valid, dvalid, ovf;
    logic [31:0] ain, din, dout;
    logic [3:0]  addr;

    logic        s_aresetn, s_we, s_valid, s_dvalid, s_ovf;
    logic [31:0] s_ain, s_din, s_dout;
    logic [3:0]  s_addr;

    pe_mac_fx #(.L_RAM_SIZE(4), .MUL_LAT(MUL_LAT), .FRAC_BITS(FRAC_BITS)) dut (
        .aclk(aclk), .aresetn(aresetn), .ain(ain), .din(din), .addr(addr),
        .we(we), .valid(valid), .dvalid(dvalid), .dout(dout), .ovf(ovf));

    pe_mac_fx #(.L_RAM_SIZE(4), .MUL_LAT(1), .FRAC_BITS(0)) dut_s (
        .aclk(aclk), .aresetn(s_aresetn), .ain(s_ain), .din(s_din), .addr(s_addr),
        .we(s_we), .valid(s_valid), .dvalid(s_dvalid), .dout(s_dout), .ovf(s_ovf));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [31:0] val;
        bit          ovf;
    } res_t;

    logic [31:0] lram_m [16];
    longint      acc_m;
    bit          ovf_m;
    res_t        pend[$];
    logic        exp_dv;
    logic [31:0] exp_dout;
    logic        exp_ovf;

    function automatic longint clamp32(input longint x, inout bit f);
        if (x > SMAX) begin f = 1'b1; return SMAX; end
        if (x < SMIN) begin f = 1'b1; return SMIN; end
        return x;
    endfunction

    // Drive one clock of inputs, advance the model, and land #1 after the edge.
    task automatic cycle(input logic rn, input logic v, input logic w,
                         input logic [3:0] a, input logic [31:0] ai, input logic [31:0] di);
        longint p, t;
        bit     f;
        res_t   r;
        aresetn = rn; valid = v; we = w; addr = a; ain = ai; din = di;
        @(posedge aclk);
        cyc++;
        if (!rn) begin
            pend.delete();
            acc_m = 0; ovf_m = 1'b0;
            exp_dv = 1'b0; exp_dout = '0; exp_ovf = 1'b0;
        end else if (v) begin
            p = longint'($signed(lram_m[a])) * longint'($signed(ai));
            t = p >>> FRAC_BITS;
            f = 1'b0;
            t = clamp32(t, f);
            acc_m = clamp32(acc_m + t, f);
            ovf_m = ovf_m | f;
            r.due = cyc + MUL_LAT; r.val = acc_m[31:0]; r.ovf = ovf_m;
            pend.push_back(r);
        end
        if (w) lram_m[a] = di;
        #1;
        if (rn) begin
            exp_dv = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_dv = 1'b1; exp_dout = pend[0].val; exp_ovf = pend[0].ovf;
                void'(pend.pop_front());
            end
        end
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 32'd5, 32'd0);
        n_cmp++; if (dvalid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid got %b want 0", dvalid); end
        n_cmp++; if (dout !== 32'd0) begin n_err++; $display("FAIL reset_dout got %h want 0", dout); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        idle();
        n_cmp++; if (dvalid !== 1'b0) begin n_err++; $display("FAIL reset_valid_ignored got %b want 0", dvalid); end
    endtask

    task automatic test_serial();
        logic [31:0] row [4];
        int cnt, lat;
        row[0] = 32'h0001_0000; row[1] = 32'h0002_0000;
        row[2] = 32'hFFFE_8000; row[3] = 32'h0000_8000;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i), 32'd0, row[i]);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'(i), 32'h0002_0000, 32'd0);
            cnt = 1; lat = 0;
            for (int k = 0; k < 7; k++) begin
                idle();
                cnt++;
                if (dvalid === 1'b1 && lat == 0) lat = cnt;
                n_cmp++;
                if (dvalid !== exp_dv || dout !== exp_dout) begin
                    n_err++;
                    $display("FAIL serial_op%0d got dv=%b dout=%h want dv=%b dout=%h", i, dvalid, dout, exp_dv, exp_dout);
                end
            end
            n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL serial_latency op%0d got %0d want %0d", i, lat, LAT); end
        end
        n_cmp++; if (dout !== 32'h0004_0000) begin n_err++; $display("FAIL serial_final got %h want 00040000", dout); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL serial_ovf got %b want 0", ovf); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [4];
        logic [31:0] got[$];
        int first, last;
        want[0] = 32'h0002_0000; want[1] = 32'h0006_0000;
        want[2] = 32'h0003_0000; want[3] = 32'h0004_0000;
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        first = 0; last = 0;
        for (int n = 1; n <= 12; n++) begin
            if (n <= 4) cycle(1'b1, 1'b1, 1'b0, 4'(n-1), 32'h0002_0000, 32'd0);
            else        idle();
            if (dvalid === 1'b1) begin
                got.push_back(dout);
                if (first == 0) first = n;
                last = n;
            end
            n_cmp++;
            if (dvalid !== exp_dv || dout !== exp_dout) begin
                n_err++;
                $display("FAIL b2b_cycle%0d got dv=%b dout=%h want dv=%b dout=%h", n, dvalid, dout, exp_dv, exp_dout);
            end
        end
        n_cmp++; if (first != LAT || last != LAT + 3) begin n_err++; $display("FAIL b2b_window got %0d..%0d want %0d..%0d", first, last, LAT, LAT + 3); end
        n_cmp++;
        if (got.size() != 4) begin
            n_err++; $display("FAIL b2b_count got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got[i] !== want[i]) begin n_err++; $display("FAIL b2b_value%0d got %h want %h", i, got[i], want[i]); end
            end
        end
    endtask

    task automatic test_saturation();
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 32'h7FFF_FFFF);
        cycle(1'b1, 1'b0, 1'b1, 4'd1, 32'd0, 32'h0001_0000);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, 32'h7FFF_FFFF, 32'd0);
        for (int i = 0; i < 6; i++) idle();
        n_cmp++; if (dout !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sat_dout got %h want 7fffffff", dout); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", ovf); end
        cycle(1'b1, 1'b1, 1'b0, 4'd1, 32'hFFFF_0000, 32'd0);
        for (int i = 0; i < 6; i++) idle();
        n_cmp++; if (dout !== 32'h7FFE_FFFF) begin n_err++; $display("FAIL sat_negterm got %h want 7ffeffff", dout); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_sticky got %b want 1", ovf); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b1, 1'b0, 4'd1, 32'h0001_0000, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 4'd1, 32'h0001_0000, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 4'd1, 32'h0001_0000, 32'd0);
        for (int i = 0; i < 8; i++) begin
            idle();
            n_cmp++; if (dvalid !== 1'b0) begin n_err++; $display("FAIL midreset_dvalid cyc%0d got %b want 0", i, dvalid); end
        end
        n_cmp++; if (dout !== 32'd0) begin n_err++; $display("FAIL midreset_dout got %h want 0", dout); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL midreset_ovf got %b want 0", ovf); end
    endtask

    task automatic test_rbw();
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 4'd2, 32'd0, 32'hFFFE_8000);
        cycle(1'b1, 1'b1, 1'b1, 4'd2, 32'h0001_0000, 32'h0003_0000);
        for (int i = 0; i < 5; i++) idle();
        n_cmp++; if (dout !== 32'hFFFE_8000) begin n_err++; $display("FAIL rbw_old got %h want fffe8000", dout); end
        cycle(1'b1, 1'b1, 1'b0, 4'd2, 32'h0001_0000, 32'd0);
        for (int i = 0; i < 5; i++) idle();
        n_cmp++; if (dout !== 32'h0001_8000) begin n_err++; $display("FAIL rbw_new got %h want 00018000", dout); end
    endtask

    task automatic test_random();
        logic        v, w, rn;
        logic [3:0]  a;
        logic [31:0] ai, di;
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i), 32'd0, 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000);
        for (int i = 0; i < 600; i++) begin
            rn = (i % 97) != 96;
            v  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 3) == 0);
            a  = 4'($urandom_range(0, 15));
            ai = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
            di = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
            if (!v && !w) begin a = 4'bx; ai = 32'bx; end
            cycle(rn, v, w, a, ai, di);
            n_cmp++;
            if (dvalid !== exp_dv || dout !== exp_dout || ovf !== exp_ovf) begin
                n_err++;
                $display("FAIL random_cyc%0d got dv=%b dout=%h ovf=%b want dv=%b dout=%h ovf=%b",
                         i, dvalid, dout, ovf, exp_dv, exp_dout, exp_ovf);
            end
        end
    endtask

    task automatic test_small_build();
        s_aresetn = 1'b0;
        @(posedge aclk); #1;
        n_cmp++; if (s_dvalid !== 1'b0 || s_dout !== 32'd0) begin n_err++; $display("FAIL small_reset got dv=%b dout=%h want 0/0", s_dvalid, s_dout); end
        s_aresetn = 1'b1; s_we = 1'b1; s_addr = 4'd0; s_din = 32'd7;
        @(posedge aclk); #1;
        s_we = 1'b0; s_valid = 1'b1; s_ain = -32'sd3;
        @(posedge aclk); #1;
        s_valid = 1'b0; s_ain = 32'bx;
        n_cmp++; if (s_dvalid !== 1'b0) begin n_err++; $display("FAIL small_early got %b want 0", s_dvalid); end
        @(posedge aclk); #1;
        n_cmp++; if (s_dvalid !== 1'b1) begin n_err++; $display("FAIL small_latency got %b want 1", s_dvalid); end
        n_cmp++; if (s_dout !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL small_dout got %h want ffffffeb", s_dout); end
        @(posedge aclk); #1;
        n_cmp++; if (s_dvalid !== 1'b0 || s_ovf !== 1'b0) begin n_err++; $display("FAIL small_after got dv=%b ovf=%b want 0/0", s_dvalid, s_ovf); end
    endtask

    initial begin
        aresetn = 1'b0; we = 1'b0; valid = 1'b0; ain = '0; din = '0; addr = '0;
        s_aresetn = 1'b0; s_we = 1'b0; s_valid = 1'b0; s_ain = '0; s_din = '0; s_addr = '0;
        acc_m = 0; ovf_m = 1'b0; exp_dv = 1'b0; exp_dout = '0; exp_ovf = 1'b0;
        for (int i = 0; i < 16; i++) lram_m[i] = '0;
        test_reset();
        test_serial();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_rbw();
        test_random();
        test_small_build();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
